// File: rtl/score_pkg.sv
// score_pkg: segment encodings, FSM states and BCD compare shared by the score display.
package score_pkg;
  localparam int MAX_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  typedef enum logic [1:0] {PLAY, CMP, OVER} state_e;
  // The first differing digit from the MSD decides; callers zero-extend narrower scores.
  function automatic logic bcd_gt(input logic [4*MAX_DIGITS-1:0] a, input logic [4*MAX_DIGITS-1:0] b);
    logic gt, done;
    gt = 1'b0;
    done = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--)
      if (!done && a[4*i+:4] != b[4*i+:4]) begin
        gt = a[4*i+:4] > b[4*i+:4];
        done = 1'b1;
      end
    return gt;
  endfunction
endpackage

// File: rtl/score_board_seg7_digit.sv
// seg7_digit: one BCD digit to active-low seven segments.
//   bcd_i   digit value; values above 9 show blank
//   blank_i force blank
//   seg_o   active-low segments {g,f,e,d,c,b,a}
module seg7_digit
  import score_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  assign seg_o = (blank_i || bcd_i > 4'd9) ? SEG_BLANK : SEG_DIGIT[bcd_i];
endmodule

// File: rtl/score_board.sv
// score_board: best-score keeper and HEX display driver for the BCD score counters.
//   clk, reset  clock, synchronous active-high reset (clears best too)
//   score_bcd   current score, digit 0 in [3:0]
//   score_ovf   carry out of the top digit counter
//   game_over   level, high while the game is over
//   hex_cur     active-low segments of the current score
//   hex_best    active-low segments of the best score (blinks on a new record)
//   best_bcd    best score
//   new_record  last game set a new best
module score_board
  import score_pkg::*;
#(
  parameter int DIGITS     = 3,
  parameter int BLINK_BITS = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   score_bcd,
  input  logic                  score_ovf,
  input  logic                  game_over,
  output logic [7*DIGITS-1:0]   hex_cur,
  output logic [7*DIGITS-1:0]   hex_best,
  output logic [4*DIGITS-1:0]   best_bcd,
  output logic                  new_record
);
  localparam logic [7*DIGITS-1:0] HEX_RESET = {{(DIGITS-1){SEG_BLANK}}, SEG_DIGIT[0]};
  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   best_q, best_d, eff, cur_src;
  logic                  rec_q, rec_d, maxed_q, maxed_d, go_q, gt, blink_off, z_c, z_b;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [7*DIGITS-1:0]   hex_cur_q, hex_best_q, cur_seg, best_seg;
  logic [DIGITS-1:0]     cur_blank, best_blank;
  assign cur_src    = maxed_q ? {DIGITS{4'h9}} : score_bcd;
  assign gt         = bcd_gt((4*MAX_DIGITS)'(eff), (4*MAX_DIGITS)'(best_q));
  assign blink_off  = rec_q & blink_q[BLINK_BITS-1];
  assign hex_cur    = hex_cur_q;
  assign hex_best   = hex_best_q;
  assign best_bcd   = best_q;
  assign new_record = rec_q;
  // Invalid digits compare as 9; the leading-zero mask walks down from the MSD.
  always_comb begin
    eff = '0;
    cur_blank = '0;
    best_blank = '0;
    z_c = 1'b1;
    z_b = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      eff[4*i+:4] = cur_src[4*i+:4] > 4'd9 ? 4'd9 : cur_src[4*i+:4];
    for (int i = DIGITS - 1; i > 0; i--) begin
      z_c = z_c & (cur_src[4*i+:4] == 4'd0);
      z_b = z_b & (best_q[4*i+:4] == 4'd0);
      cur_blank[i] = z_c;
      best_blank[i] = z_b;
    end
  end
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_digit u_cur (.bcd_i(cur_src[4*g+:4]), .blank_i(cur_blank[g]), .seg_o(cur_seg[7*g+:7]));
    seg7_digit u_best (.bcd_i(best_q[4*g+:4]), .blank_i(best_blank[g] | blink_off), .seg_o(best_seg[7*g+:7]));
  end
  always_comb begin
    state_d = state_q;
    best_d = best_q;
    rec_d = rec_q;
    maxed_d = maxed_q;
    blink_d = '0;
    case (state_q)
      PLAY: begin
        maxed_d = maxed_q | score_ovf;
        state_d = (game_over && !go_q) ? CMP : PLAY;
      end
      CMP: begin
        best_d = gt ? eff : best_q;
        rec_d = gt;
        state_d = OVER;
      end
      OVER: begin
        state_d = game_over ? OVER : PLAY;
        rec_d = game_over & rec_q;
        maxed_d = game_over & maxed_q;
        blink_d = game_over ? blink_q + 1'b1 : '0;
      end
      default: state_d = PLAY;
    endcase
  end
  // Sampled even during reset so a level already high at release is not an edge.
  always_ff @(posedge clk) go_q <= game_over;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= PLAY;
      best_q <= '0;
      rec_q <= 1'b0;
      maxed_q <= 1'b0;
      blink_q <= '0;
      hex_cur_q <= HEX_RESET;
      hex_best_q <= HEX_RESET;
    end else begin
      state_q <= state_d;
      best_q <= best_d;
      rec_q <= rec_d;
      maxed_q <= maxed_d;
      blink_q <= blink_d;
      hex_cur_q <= cur_seg;
      hex_best_q <= best_seg;
    end
endmodule

// File: tb/tb_score_board.sv
// tb_score_board: randomized and directed scoreboard bench for score_board.
module tb_score_board;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] score_bcd = '0;
  logic        score_ovf = 1'b0;
  logic        game_over = 1'b0;
  logic [20:0] hex_cur, hex_best;
  logic [11:0] best_bcd;
  logic        new_record;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct { logic [20:0] cur, best; logic [11:0] bb; logic rec; } exp_t;
  exp_t q[$];
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int pw [3] = '{1, 10, 100};
  int m_mode, m_best, m_blink;
  bit m_rec, m_max;
  logic m_prev = 1'b0;
  logic [20:0] m_cur, m_hbest;
  score_board #(.DIGITS(3), .BLINK_BITS(3)) dut (
    .clk(clk), .reset(reset), .score_bcd(score_bcd), .score_ovf(score_ovf), .game_over(game_over),
    .hex_cur(hex_cur), .hex_best(hex_best), .best_bcd(best_bcd), .new_record(new_record)
  );
  always #5 clk = ~clk;
  function automatic int dec(input logic [11:0] b);
    int v = 0;
    for (int i = 0; i < 3; i++) v += (b[4*i+:4] > 9 ? 9 : int'(b[4*i+:4])) * pw[i];
    return v;
  endfunction
  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic logic [20:0] disp(input logic [11:0] b);
    logic [20:0] r;
    int v = dec(b);
    for (int i = 0; i < 3; i++)
      r[7*i+:7] = (b[4*i+:4] > 9 || (i > 0 && v < pw[i])) ? 7'h7F : seg_tab[b[4*i+:4]];
    return r;
  endfunction
  task automatic model_step();
    logic [20:0] ncur, nhb;
    int eff;
    if (reset) begin
      m_mode = 0; m_best = 0; m_rec = 0; m_max = 0; m_blink = 0;
      m_cur = {7'h7F, 7'h7F, seg_tab[0]};
      m_hbest = m_cur;
    end else begin
      ncur = disp(m_max ? 12'h999 : score_bcd);
      nhb = (m_rec && m_blink >= 4) ? 21'h1FFFFF : disp(to_bcd(m_best));
      if (m_mode == 0) begin
        if (score_ovf) m_max = 1;
        if (game_over && !m_prev) m_mode = 1;
      end else if (m_mode == 1) begin
        eff = m_max ? 999 : dec(score_bcd);
        m_rec = eff > m_best;
        if (m_rec) m_best = eff;
        m_mode = 2;
      end else begin
        m_blink = (m_blink + 1) % 8;
        if (!game_over) begin m_mode = 0; m_rec = 0; m_max = 0; m_blink = 0; end
      end
      m_cur = ncur;
      m_hbest = nhb;
    end
    m_prev = game_over;
    q.push_back('{cur: m_cur, best: m_hbest, bb: to_bcd(m_best), rec: m_rec});
  endtask
  task automatic cyc(input logic [11:0] s, input logic o, input logic g, input logic r);
    score_bcd = s; score_ovf = o; game_over = g; reset = r;
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("hex_cur", 32'(hex_cur), 32'(e.cur));
      chk("hex_best", 32'(hex_best), 32'(e.best));
      chk("best_bcd", 32'(best_bcd), 32'(e.bb));
      chk("new_record", 32'(new_record), 32'(e.rec));
    end
  initial begin
    logic g;
    logic [11:0] s;
    repeat (2) cyc(12'h000, 0, 0, 1);
    cyc(12'h047, 0, 1, 1);
    repeat (3) cyc(12'h047, 0, 1, 0);
    cyc(12'h047, 0, 0, 0);
    repeat (2) cyc(12'h047, 0, 0, 0);
    repeat (2) cyc(12'h100, 0, 0, 0);
    cyc(12'h047, 0, 0, 0);
    repeat (20) cyc(12'h047, 0, 1, 0);
    repeat (2) cyc(12'h031, 0, 0, 0);
    repeat (8) cyc(12'h031, 0, 1, 0);
    repeat (2) cyc(12'h047, 0, 0, 0);
    repeat (8) cyc(12'h047, 0, 1, 0);
    repeat (2) cyc(12'h999, 0, 0, 0);
    cyc(12'h000, 1, 0, 0);
    repeat (3) cyc(12'h002, 0, 0, 0);
    repeat (6) cyc(12'h002, 0, 1, 0);
    repeat (2) cyc(12'h000, 0, 0, 1);
    repeat (2) cyc(12'h998, 0, 0, 0);
    cyc(12'h000, 1, 1, 0);
    repeat (6) cyc(12'h000, 0, 1, 0);
    repeat (2) cyc(12'h000, 0, 0, 1);
    cyc(12'h047, 0, 0, 0);
    repeat (5) cyc(12'h047, 0, 1, 0);
    cyc(12'h047, 0, 1, 1);
    repeat (3) cyc(12'h047, 0, 1, 0);
    cyc(12'h0A5, 0, 0, 0);
    cyc(12'h00C, 0, 0, 0);
    g = 1'b0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++)
        s[4*i+:4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0) s[11:8] = 4'd0;
      if ($urandom_range(0, 14) == 0) g = ~g;
      cyc(s, $urandom_range(0, 24) == 0, g, $urandom_range(0, 199) == 0);
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
